// File: rtl/in_port_buffer.sv
// Receive-side byte buffer for the core's input port: a small first-word-fall-through FIFO
// with a valid/ready producer side, a read-strobe consumer side and sticky error flags.
module in_port_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              full, empty;
  logic              wr_acc, rd_acc;

  // Flags come only from the registered count: no path from valid/rd_en to ready.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = i_wr_valid && !full;
  assign rd_acc = i_rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new offending attempt wins over a coincident clear.
    ovf_d = (i_wr_valid && full) || (ovf_q && !i_clr_err);
    unf_d = (i_rd_en && empty) || (unf_q && !i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_wr_ready  = !full;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: doc/in_port_buffer.md
Name: in_port_buffer

Overview:
- Input-side peripheral that buffers bytes from an external producer and presents them to the CPU core's 8-bit input port (`i_in` of `top`). It is the receive-direction counterpart of the core's output port.
- Contains a small first-word-fall-through (FWFT) FIFO, a valid/ready write handshake toward the producer, a read-strobe consume interface toward the core, and sticky overflow/underflow flags for software polling.

Parameters:
- DATA_W, 8, byte width; it matches the core's `i_in` width.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_wr_valid  in  1  producer presents a byte.
- i_wr_data  in  DATA_W  producer byte.
- o_wr_ready  out  1  buffer can accept a byte; equals !o_full.
- i_rd_en  in  1  core consumes the head byte, one byte per cycle high.
- o_rd_data  out  DATA_W  head byte (FWFT); drives the core's `i_in`.
- o_empty  out  1  FIFO holds 0 entries.
- o_full  out  1  FIFO holds DEPTH entries.
- o_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky flag: a write was attempted while full.
- o_underflow  out  1  sticky flag: a read was attempted while empty.
- i_clr_err  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async assert, sync release to i_clk):
  - wr_ptr = rd_ptr = 0, count = 0.
  - o_empty=1, o_full=0, o_wr_ready=1, o_overflow=0, o_underflow=0, o_rd_data=0.
  - Storage array is not reset.
  - Reset asserted mid-transfer discards all contents; the in-flight write is lost.
- Write:
  - Accepted on a rising edge when i_wr_valid && !o_full.
  - The byte is stored at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap, pointer width log2(DEPTH)).
- Read:
  - Accepted on a rising edge when i_rd_en && !o_empty.
  - rd_ptr increments modulo DEPTH.
- o_rd_data:
  - Equals mem[rd_ptr] when !o_empty; forced to 0 when o_empty.
  - A byte written at edge N appears on o_rd_data after edge N, i.e. 1-cycle write-to-read latency.
  - After an accepted read at edge N, the next byte (or 0 if now empty) is visible after edge N.
- Count update per edge:
  - +1 on write only, −1 on read only.
  - Unchanged when both are accepted or neither is.
  - o_full = (count==DEPTH); o_empty = (count==0). Both derive from the registered count, so there is no combinational path from i_wr_valid or i_rd_en to the flags.
- Simultaneous write + read:
  - When neither full nor empty: both accepted, count unchanged, FIFO order preserved.
  - When full: the read is accepted and the write is rejected, because ready reflects the registered full flag. o_overflow sets. The producer must hold valid/data until it sees ready.
  - When empty: the write is accepted and the read is ignored. o_underflow sets, count becomes 1, and o_rd_data shows the new byte the next cycle.
- Sticky flags:
  - Set on the edge where the offending attempt occurs.
  - Held until i_clr_err or reset.
  - If i_clr_err coincides with a new offending event, set wins and the flag stays 1.
- Handshake rules:
  - The producer must not change i_wr_data while i_wr_valid && !o_wr_ready.
  - The buffer never drops an accepted byte.

Test Plan:
1. Reset then idle: assert i_rst 20 ns, release → o_empty=1, o_full=0, o_wr_ready=1, o_count=0, o_rd_data=8'h00, both flags 0.
2. Fill/drain order: write 8'hA1, 8'hB2, 8'hC3, 8'hD4 on consecutive cycles.
   - After the 4th write: o_full=1, o_wr_ready=0, o_count=4, o_rd_data=8'hA1.
   - Pulse i_rd_en 4 cycles → o_rd_data sequence A1, B2, C3, D4, then 00 with o_empty=1.
3. Overflow: with the FIFO full, hold i_wr_valid=1, data 8'hEE, for 1 cycle.
   - Count stays 4, o_overflow=1, and 8'hEE never appears at the output.
   - Pulse i_clr_err → o_overflow=0.
4. Underflow with simultaneous write: FIFO empty; in the same cycle i_rd_en=1, i_wr_valid=1, data 8'h5A.
   - Next cycle: o_count=1, o_rd_data=8'h5A, o_underflow=1.
5. Pointer wrap under steady streaming: write 10 bytes 8'h00..8'h09 while reading every cycle after the first write.
   - Output sequence is 00..09 in order.
   - o_count never exceeds 1.
   - Pointers wrap at least twice.
6. Reset mid-operation: with 3 bytes stored (o_count=3), assert i_rst asynchronously between edges.
   - Outputs return to reset values immediately, without waiting for a clock edge.
   - After release, a single write of 8'h77 → o_rd_data=8'h77, o_count=1.
